// File: rtl/clk_div_ctrl_if.sv
// Divisor-offer handshake between a divisor source (master) and
// clk_div_ctrl (slave). The master offers a divisor with div_valid_i and
// div_value_i. The slave takes it in any cycle where it also drives
// div_ready_o high.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             div_valid_i;
  logic [CNT_W-1:0] div_value_i;
  logic             div_ready_o;

  modport master (
    output div_valid_i,
    output div_value_i,
    input  div_ready_o
  );

  modport slave (
    input  div_valid_i,
    input  div_value_i,
    output div_ready_o
  );

endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable / square-wave divider with glitch-free
// divisor changes.
//
// A phase counter runs from 0 to D-1, where D = div_active_o. Registered
// decodes of that counter produce two outputs:
//   - clk_o, a square wave that is high for floor(D/2) of every D cycles
//     (always high when D == 1);
//   - clk_en_o, a one-cycle pulse once per period.
// D == 0 stops both outputs.
//
// A new divisor arrives over the valid/ready interface and is parked in a
// pending register. It takes effect only at the end of the period in
// progress, so an output period is never cut short.
//
// Optional feature: define CLK_DIV_CTRL_SWITCH_CNT_EN to add switch_cnt_o.
// This is a saturating 8-bit count of applied divisor changes.
module clk_div_ctrl #(
  parameter int          CNT_W     = 16,
  parameter int unsigned RESET_DIV = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  clk_div_ctrl_if.slave    div_if,
  output logic             clk_o,
  output logic             clk_en_o,
  output logic [CNT_W-1:0] div_active_o,
  output logic             running_o
`ifdef CLK_DIV_CTRL_SWITCH_CNT_EN
  ,
  output logic [7:0]       switch_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] RESET_DIV_W = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,   // nothing pending, ready for an offer
    PEND,   // divisor parked, waiting for the period boundary
    APPLY   // new divisor in effect, first cycle of its period
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic             ready_q;

  logic             stopped;
  logic             boundary;
  logic             apply_go;
  logic [CNT_W-1:0] half_div;

  // A stopped divider has no period, so every cycle counts as a boundary.
  // This lets a pending divisor land on the cycle right after acceptance.
  assign stopped   = (div_active_o == '0);
  assign boundary  = stopped || (cnt == div_active_o - ONE);
  assign apply_go  = (state == PEND) && boundary;
  assign half_div  = div_active_o >> 1;

  assign running_o          = !stopped;
  assign div_if.div_ready_o = ready_q;

  // Control FSM: accept an offer, hold it until the period ends, then apply it.
  // NOTE: sequential state uses non-blocking (<=) assignments. Every flop
  // then samples pre-edge values, whatever order the always blocks run in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      pend_div     <= '0;
      div_active_o <= RESET_DIV_W;
      ready_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (div_if.div_valid_i && ready_q) begin
            pend_div <= div_if.div_value_i;
            state    <= PEND;
            ready_q  <= 1'b0;
          end
        end
        PEND: begin
          if (boundary) begin
            div_active_o <= pend_div;
            state        <= APPLY;
          end
        end
        APPLY: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Phase counter. It restarts at 0 whenever a divisor is applied, and it
  // stays parked at 0 while the divider is stopped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (apply_go || stopped) begin
      cnt <= '0;
    end else if (cnt == div_active_o - ONE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  // Registered output decode. It lags the phase counter by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_o    <= 1'b0;
      clk_en_o <= 1'b0;
    end else begin
      clk_o    <= (div_active_o == ONE) ||
                  ((div_active_o > ONE) && (cnt < half_div));
      clk_en_o <= !stopped && (cnt == '0);
    end
  end

`ifdef CLK_DIV_CTRL_SWITCH_CNT_EN
  // Saturating count of applied divisor changes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      switch_cnt_o <= 8'd0;
    end else if (apply_go && (switch_cnt_o != 8'hFF)) begin
      switch_cnt_o <= switch_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the divisor and phase counter.
REQ-002 SHALL have parameter RESET_DIV, default 4: divisor active out of reset; legal range 0 to 2^CNT_W-1.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port div_valid_i, input, 1 bit: a new divisor is offered.
REQ-006 SHALL have port div_value_i, input, CNT_W bits: the offered divisor; 0 means stop.
REQ-007 SHALL have port div_ready_o, output, 1 bit: the controller can accept a divisor.
REQ-008 SHALL have port clk_o, output, 1 bit: registered divided square wave.
REQ-009 SHALL have port clk_en_o, output, 1 bit: registered one-cycle pulse, once per output period.
REQ-010 SHALL have port div_active_o, output, CNT_W bits: the divisor currently in effect.
REQ-011 SHALL have port running_o, output, 1 bit: high when div_active_o is not 0.

Function
REQ-012 SHALL keep a phase counter cnt that counts 0 to D-1 and wraps to 0, where D = div_active_o, whenever D >= 1.
REQ-013 SHALL set clk_o in cycle N+1 to 1 iff cycle N had D >= 2 and cnt < D/2 (floor), or had D == 1.
REQ-014 SHALL set clk_en_o in cycle N+1 to 1 iff cycle N had D >= 1 and cnt == 0; latency from counter to outputs is 1 cycle.
REQ-015 SHALL, when D == 0, hold cnt at 0 and drive clk_o = 0 and clk_en_o = 0 from the following cycle.
REQ-016 SHALL accept a divisor when div_valid_i and div_ready_o are both 1, storing it in a pending register.
REQ-017 SHALL drive div_ready_o = 1 only in state IDLE.
REQ-018 SHALL use three states: IDLE (no pending divisor), PEND (divisor stored and waiting), APPLY (one cycle).
REQ-019 SHALL go IDLE -> PEND on acceptance.
REQ-020 SHALL go PEND -> APPLY at the period boundary: the cycle where cnt == D-1, or the cycle right after acceptance if D == 0.
REQ-021 SHALL, in APPLY, load div_active_o from the pending register, force cnt to 0 and return to IDLE; the new period starts in that same cycle.
REQ-022 SHALL never truncate a period that is in progress, so clk_o has no runt high or low pulse.
REQ-023 SHALL, when D == 1, make every cycle a boundary, so a pending divisor is applied the cycle after acceptance.
REQ-024 SHALL not sample div_value_i or div_valid_i while in PEND or APPLY.
REQ-025 SHALL, when a newly applied divisor equals the old one, still restart the phase, with cnt = 0 and a clk_en_o pulse 1 cycle later.
REQ-026 SHALL accept a divisor in the cycle after APPLY at the earliest; the sustained rate is at most one change per output period.

Reset
REQ-027 SHALL, while rst_ni = 0, immediately force: cnt = 0, div_active_o = RESET_DIV, state = IDLE, pending register = 0, clk_o = 0, clk_en_o = 0.
REQ-028 SHALL drive div_ready_o = 1 and running_o = (RESET_DIV != 0) during and after reset.
REQ-029 SHALL, when reset is asserted while in PEND, discard the pending divisor; div_active_o returns to RESET_DIV.
REQ-030 SHALL show the first counter decode on the outputs 1 cycle after rst_ni rises.

Configuration
REQ-031 SHALL, with macro CLK_DIV_CTRL_SWITCH_CNT_EN defined, add output switch_cnt_o (8 bits) that increments on every APPLY, saturates at 255 and resets to 0.
REQ-032 SHALL, with CLK_DIV_CTRL_SWITCH_CNT_EN undefined, have no switch_cnt_o port and no counter logic; all other behaviour is identical.

Verification
REQ-033 SHALL cover default reset: RESET_DIV=4, release reset -> clk_o reads 1,1,0,0 repeating from cycle 1, and clk_en_o pulses every 4 cycles.
REQ-034 SHALL cover a mid-period change: D=4; offer 6 when cnt=1 -> ready drops next cycle; the new period starts after cnt=3; then clk_o is 3 high / 3 low; ready returns after APPLY.
REQ-035 SHALL cover stop and restart: D=4; offer 0 -> after the boundary clk_o=0, clk_en_o=0, running_o=0; offer 2 -> applied the cycle after acceptance, then clk_o toggles 1,0.
REQ-036 SHALL cover odd and unity divisors: D=3 -> clk_o 1 high / 2 low; D=1 -> clk_o stays 1 and clk_en_o is 1 every cycle.
REQ-037 SHALL cover back-to-back offers: hold div_valid_i=1 with value 5 then 7 -> 7 is accepted only after APPLY of 5, so each divisor runs at least one full period.
REQ-038 SHALL cover reset in PEND: D=8, pending 3, assert rst_ni=0 -> div_active_o=RESET_DIV, ready=1, and 3 is never applied; with the macro, switch_cnt_o=0.
